argmax_top2: RTL and testbench
==============================

# argmax_top2

Parametrised argmax stage for the output layer of the digit-recognition network. The block accepts one packed vector of `N_IN` scores with a valid/ready handshake and scans it `LANES` elements per cycle. It reports the winning class index, the best score, the runner-up score and their margin, which serves as a confidence value. Results are held under an output valid/ready handshake, so the block sits between the last neuron layer and the result/display logic with back-pressure on both sides.

## Interface
- `N_IN`, 10: number of scores per vector; must be ≥ 2.
- `DATA_W`, 16: score width in bits.
- `LANES`, 1: scores compared per scan cycle, range 1..`N_IN`.
- `SIGNED_MODE`, 1: 1 treats scores as two's complement, 0 as unsigned.
- `IDX_W`, `$clog2(N_IN)`: width of the index output.
- `clk` in 1: clock.
- `rst_n` in 1: reset, synchronous, active-low.
- `in_valid` in 1: an input vector is presented.
- `in_ready` out 1: the block can accept a vector; high only in IDLE.
- `in_data` in `N_IN*DATA_W`: the scores; element i is `in_data[i*DATA_W +: DATA_W]`.
- `out_valid` out 1: the result is valid and is held until accepted.
- `out_ready` in 1: the downstream stage accepts the result.
- `out_idx` out `IDX_W`: index of the maximum score.
- `out_max` out `DATA_W`: the maximum score.
- `out_second` out `DATA_W`: the second-highest score; duplicates count.
- `out_margin` out `DATA_W`: `out_max - out_second`, unsigned.

## Operation
- The FSM has three states: IDLE, SCAN and DONE. `in_ready = (state == IDLE)`.
- **IDLE**
  - When `in_valid && in_ready`, the block captures `in_data` into a buffer.
  - It sets `best = second = MINV`, `best_idx = 0` and `grp = 0`, then moves to SCAN.
  - `MINV` is `-2^(DATA_W-1)` when `SIGNED_MODE = 1` and 0 otherwise.
- **SCAN**
  - Each cycle processes elements `grp*LANES .. grp*LANES+LANES-1` in ascending index order, through a combinational chain within the cycle.
  - Elements with index ≥ `N_IN` are ignored; this covers the padding in the last group.
  - Per element x at index i:
    - If `x > best`, then `second = best`, `best = x` and `best_idx = i`.
    - Otherwise, if `x > second`, then `second = x`.
  - Comparisons are strict and follow `SIGNED_MODE`.
  - `grp` increments each cycle. After group `G-1`, where `G = ceil(N_IN/LANES)`, the block moves to DONE.
  - It registers the outputs and sets `out_valid = 1`.
- **DONE**
  - Outputs are held stable while `out_valid && !out_ready`.
  - On `out_valid && out_ready`, `out_valid` clears and the FSM returns to IDLE.
  - Output data registers keep their last values.
- **Ties**
  - The lowest index wins `out_idx`.
  - An equal later value becomes `second`, so the margin is 0.
- **Margin**
  - `best ≥ second` always holds, so the difference fits in `DATA_W` bits unsigned in both modes.
- **Input changes after capture**
  - `in_data` changes after the capture cycle have no effect on the result.
- **Reset**
  - Reset values: `out_valid = 0`, `out_idx = 0`, `out_max = 0`, `out_second = 0`, `out_margin = 0`, state IDLE.
  - Reset during SCAN or DONE abandons the vector and produces no output.
  - Inputs are ignored while `rst_n = 0`.

## Timing
- Capture happens at edge 0, when the handshake fires.
- SCAN occupies edges 1..G. `out_valid` rises after edge G.
- Latency from capture to result is G+1 edges: 11 for the defaults, 3 for `N_IN = 10, LANES = 5`.
- `in_ready` is low from the cycle after capture until the cycle after the output handshake.
- Maximum throughput is one vector per G+2 cycles with `out_ready` held high.
- The path per cycle is a chain of `LANES` compare-update steps. `LANES` trades latency against clock rate.

## Structure
- The shared package `nn_pkg` holds:
  - the FSM state enum `argmax_state_t` (IDLE/SCAN/DONE);
  - a function for the `MINV` constant;
  - the `DATA_W` default shared with the neuron layers.
- Sub-module `argmax_cmp_step`: a combinational single-element update.
  - Inputs: x, i, best, best_idx, second, en.
  - Outputs: the updated best, best_idx and second.
  - The top level instantiates `LANES` of these in a chain.

## Test plan
- **Unique maximum, defaults.** Input scores `{3, 9, 1, 20, 7, 0, 5, 2, 8, 4}`, signed, `LANES = 1`. Required: `out_idx = 3`, `out_max = 20`, `out_second = 9`, `out_margin = 11`; `out_valid` rises 11 edges after capture.
- **Signed all-negative with a tie.** Input scores `{-5, -2, -9, -2, …, -7}`. Required: `out_idx = 1`, `out_max = -2`, `out_second = -2`, `out_margin = 0`.
- **Unsigned mode.** `SIGNED_MODE = 0`, `0xFFFF` at index 9 and every other score `0x0001`. Required: `out_idx = 9`, `out_margin = 0xFFFE`. The same vector with `SIGNED_MODE = 1` gives `out_idx` equal to the index of the first `0x0001`, i.e. 0.
- **Multi-lane with padding.** `LANES = 4`, `N_IN = 10`, maximum at index 9. Required: G = 3, the result appears 4 edges after capture with `out_idx = 9`, and padding lanes never win.
- **Back-pressure.** `out_ready = 0` for 5 cycles after `out_valid` rises. Required: all outputs stable, `in_ready = 0`, a second `in_valid` is not accepted. `out_ready = 1` completes the handshake and `in_ready` rises on the next cycle.
- **Reset mid-scan.** `rst_n = 0` at scan cycle 4. Required: `out_valid = 0`, all outputs 0, `in_ready = 1` after release, and a new vector gives the correct result.

Source files
------------

// File: rtl/nn_pkg.sv
// Shared definitions for the digit-recognition network layers:
// common score width, argmax FSM states and the minimum-score constant.
package nn_pkg;

    localparam int NN_DATA_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } argmax_state_t;

    // Smallest representable score: only the sign bit set in signed mode, zero otherwise.
    function automatic logic [63:0] argmax_minv(input int data_w, input bit signed_mode);
        logic [63:0] r;
        r = '0;
        if (signed_mode) begin
            r[data_w-1] = 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/argmax_cmp_step.sv
// One combinational argmax update: folds score x at index i into the
// running best / best index / runner-up triple when en is set.
module argmax_cmp_step #(
    parameter int DATA_W      = 16,
    parameter int IDX_W       = 4,
    parameter bit SIGNED_MODE = 1'b1
) (
    input  logic [DATA_W-1:0] x,
    input  logic [IDX_W-1:0]  i,
    input  logic [DATA_W-1:0] best,
    input  logic [IDX_W-1:0]  best_idx,
    input  logic [DATA_W-1:0] second,
    input  logic              en,
    output logic [DATA_W-1:0] best_o,
    output logic [IDX_W-1:0]  best_idx_o,
    output logic [DATA_W-1:0] second_o
);

    // Widen by one bit so a single signed compare covers both modes.
    function automatic logic signed [DATA_W:0] ext(input logic [DATA_W-1:0] v);
        return SIGNED_MODE ? {v[DATA_W-1], v} : {1'b0, v};
    endfunction

    logic signed [DATA_W:0] x_e;
    logic signed [DATA_W:0] best_e;
    logic signed [DATA_W:0] second_e;

    assign x_e      = ext(x);
    assign best_e   = ext(best);
    assign second_e = ext(second);

    always_comb begin
        best_o     = best;
        best_idx_o = best_idx;
        second_o   = second;
        if (en) begin
            if (x_e > best_e) begin
                second_o   = best;
                best_o     = x;
                best_idx_o = i;
            end else if (x_e > second_e) begin
                second_o = x;
            end
        end
    end

endmodule

// File: rtl/argmax_top2.sv
// Argmax with runner-up and margin over a captured score vector, scanned
// LANES scores per cycle, with valid/ready handshakes on both sides.
module argmax_top2
    import nn_pkg::*;
#(
    parameter int N_IN        = 10,
    parameter int DATA_W      = NN_DATA_W,
    parameter int LANES       = 1,
    parameter bit SIGNED_MODE = 1'b1,
    parameter int IDX_W       = $clog2(N_IN)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [N_IN*DATA_W-1:0] in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [IDX_W-1:0]       out_idx,
    output logic [DATA_W-1:0]      out_max,
    output logic [DATA_W-1:0]      out_second,
    output logic [DATA_W-1:0]      out_margin
);

    localparam int G     = (N_IN + LANES - 1) / LANES;
    localparam int GRP_W = (G > 1) ? $clog2(G) : 1;
    localparam int PAD_W = G * LANES * DATA_W;
    localparam logic [DATA_W-1:0] MINV = DATA_W'(argmax_minv(DATA_W, SIGNED_MODE));

    argmax_state_t           state_q, state_d;
    logic [N_IN*DATA_W-1:0]  buf_q, buf_d;
    logic [DATA_W-1:0]       best_q, best_d;
    logic [DATA_W-1:0]       second_q, second_d;
    logic [IDX_W-1:0]        best_idx_q, best_idx_d;
    logic [GRP_W-1:0]        grp_q, grp_d;
    logic                    out_valid_q, out_valid_d;
    logic [IDX_W-1:0]        out_idx_q, out_idx_d;
    logic [DATA_W-1:0]       out_max_q, out_max_d;
    logic [DATA_W-1:0]       out_second_q, out_second_d;
    logic [DATA_W-1:0]       out_margin_q, out_margin_d;

    logic [PAD_W-1:0]        buf_pad;
    logic [DATA_W-1:0]       c_best   [0:LANES];
    logic [DATA_W-1:0]       c_second [0:LANES];
    logic [IDX_W-1:0]        c_idx    [0:LANES];

    // Pad the buffer to whole groups; padded slots are disabled by their index.
    always_comb begin
        buf_pad                  = '0;
        buf_pad[N_IN*DATA_W-1:0] = buf_q;
    end

    assign c_best[0]   = best_q;
    assign c_second[0] = second_q;
    assign c_idx[0]    = best_idx_q;

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic [31:0] pos;
        assign pos = 32'(grp_q) * 32'(LANES) + 32'(l);

        argmax_cmp_step #(
            .DATA_W      (DATA_W),
            .IDX_W       (IDX_W),
            .SIGNED_MODE (SIGNED_MODE)
        ) u_step (
            .x          (buf_pad[pos*DATA_W +: DATA_W]),
            .i          (pos[IDX_W-1:0]),
            .best       (c_best[l]),
            .best_idx   (c_idx[l]),
            .second     (c_second[l]),
            .en         (pos < 32'(N_IN)),
            .best_o     (c_best[l+1]),
            .best_idx_o (c_idx[l+1]),
            .second_o   (c_second[l+1])
        );
    end

    always_comb begin
        state_d      = state_q;
        buf_d        = buf_q;
        best_d       = best_q;
        second_d     = second_q;
        best_idx_d   = best_idx_q;
        grp_d        = grp_q;
        out_valid_d  = out_valid_q;
        out_idx_d    = out_idx_q;
        out_max_d    = out_max_q;
        out_second_d = out_second_q;
        out_margin_d = out_margin_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    buf_d      = in_data;
                    best_d     = MINV;
                    second_d   = MINV;
                    best_idx_d = '0;
                    grp_d      = '0;
                    state_d    = ST_SCAN;
                end
            end
            ST_SCAN: begin
                best_d     = c_best[LANES];
                second_d   = c_second[LANES];
                best_idx_d = c_idx[LANES];
                grp_d      = grp_q + GRP_W'(1);
                if (grp_q == GRP_W'(G - 1)) begin
                    out_valid_d  = 1'b1;
                    out_idx_d    = c_idx[LANES];
                    out_max_d    = c_best[LANES];
                    out_second_d = c_second[LANES];
                    out_margin_d = c_best[LANES] - c_second[LANES];
                    state_d      = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Scan datapath carries no reset; it is reloaded on every capture.
    always_ff @(posedge clk) begin
        buf_q      <= buf_d;
        best_q     <= best_d;
        second_q   <= second_d;
        best_idx_q <= best_idx_d;
        grp_q      <= grp_d;
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            out_valid_q  <= 1'b0;
            out_idx_q    <= '0;
            out_max_q    <= '0;
            out_second_q <= '0;
            out_margin_q <= '0;
        end else begin
            state_q      <= state_d;
            out_valid_q  <= out_valid_d;
            out_idx_q    <= out_idx_d;
            out_max_q    <= out_max_d;
            out_second_q <= out_second_d;
            out_margin_q <= out_margin_d;
        end
    end

    assign in_ready   = (state_q == ST_IDLE);
    assign out_valid  = out_valid_q;
    assign out_idx    = out_idx_q;
    assign out_max    = out_max_q;
    assign out_second = out_second_q;
    assign out_margin = out_margin_q;

endmodule

// File: tb/tb_argmax_top2.sv
// Bench for argmax_top2: three configurations (1 lane signed, 4 lanes signed,
// 1 lane unsigned) driven with directed and random vectors against a reference model.
module tb_argmax_top2;

    logic         clk;
    logic         rst_n;
    logic         in_valid   [3];
    logic [159:0] in_data    [3];
    logic         out_ready  [3];
    logic         in_ready   [3];
    logic         out_valid  [3];
    logic [3:0]   out_idx    [3];
    logic [15:0]  out_max    [3];
    logic [15:0]  out_second [3];
    logic [15:0]  out_margin [3];

    int n_cmp = 0;
    int n_bad = 0;

    argmax_top2 #(.N_IN(10), .DATA_W(16), .LANES(1), .SIGNED_MODE(1'b1)) u_d0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .in_data(in_data[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .out_idx(out_idx[0]), .out_max(out_max[0]), .out_second(out_second[0]),
        .out_margin(out_margin[0]));

    argmax_top2 #(.N_IN(10), .DATA_W(16), .LANES(4), .SIGNED_MODE(1'b1)) u_d1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .in_data(in_data[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .out_idx(out_idx[1]), .out_max(out_max[1]), .out_second(out_second[1]),
        .out_margin(out_margin[1]));

    argmax_top2 #(.N_IN(10), .DATA_W(16), .LANES(1), .SIGNED_MODE(1'b0)) u_d2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .in_data(in_data[2]), .out_valid(out_valid[2]), .out_ready(out_ready[2]),
        .out_idx(out_idx[2]), .out_max(out_max[2]), .out_second(out_second[2]),
        .out_margin(out_margin[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic longint sval(input logic [15:0] x, input bit sgn);
        return sgn ? longint'($signed(x)) : longint'(x);
    endfunction

    // Winner = first occurrence of the maximum; runner-up = maximum of all other slots.
    task automatic model(input logic [159:0] v, input bit sgn, output logic [3:0] idx,
                         output logic [15:0] mx, output logic [15:0] sc, output logic [15:0] mg);
        longint best, sec;
        int bi;
        best = sval(v[15:0], sgn);
        bi = 0;
        for (int i = 1; i < 10; i++) begin
            if (sval(v[i*16 +: 16], sgn) > best) begin
                best = sval(v[i*16 +: 16], sgn);
                bi = i;
            end
        end
        sec = -(64'sd1 <<< 40);
        for (int i = 0; i < 10; i++) begin
            if (i != bi && sval(v[i*16 +: 16], sgn) > sec) sec = sval(v[i*16 +: 16], sgn);
        end
        idx = 4'(bi);
        mx  = v[bi*16 +: 16];
        sc  = 16'(sec);
        mg  = 16'(best - sec);
    endtask

    function automatic logic [159:0] pack(input int s [10]);
        logic [159:0] v;
        for (int i = 0; i < 10; i++) v[i*16 +: 16] = 16'(s[i]);
        return v;
    endfunction

    task automatic check_out(input int k, input string tag, input logic [3:0] idx,
                             input logic [15:0] mx, input logic [15:0] sc, input logic [15:0] mg);
        chk({tag, ".idx"}, 32'(out_idx[k]), 32'(idx));
        chk({tag, ".max"}, 32'(out_max[k]), 32'(mx));
        chk({tag, ".second"}, 32'(out_second[k]), 32'(sc));
        chk({tag, ".margin"}, 32'(out_margin[k]), 32'(mg));
    endtask

    // One transaction on instance k; hold = cycles of out_ready low after out_valid rises.
    task automatic run(input int k, input logic [159:0] v, input int hold, input string tag);
        logic [3:0]  e_idx;
        logic [15:0] e_mx, e_sc, e_mg;
        int cnt;
        int g;
        g = (k == 1) ? 3 : 10;
        model(v, k != 2, e_idx, e_mx, e_sc, e_mg);
        @(negedge clk);
        chk({tag, ".in_ready"}, 32'(in_ready[k]), 32'd1);
        in_valid[k] = 1'b1;
        in_data[k]  = v;
        out_ready[k] = 1'b0;
        @(posedge clk);
        cnt = 1;
        @(negedge clk);
        in_valid[k] = 1'b0;
        in_data[k]  = {$urandom, $urandom, $urandom, $urandom, $urandom};
        while (!out_valid[k] && cnt < 40) begin
            @(posedge clk);
            cnt++;
            @(negedge clk);
        end
        chk({tag, ".latency"}, 32'(cnt), 32'(g + 1));
        if (!out_valid[k]) return;
        check_out(k, tag, e_idx, e_mx, e_sc, e_mg);
        for (int h = 0; h < hold; h++) begin
            in_valid[k] = 1'b1;
            in_data[k]  = {$urandom, $urandom, $urandom, $urandom, $urandom};
            @(posedge clk);
            @(negedge clk);
            chk({tag, ".hold_valid"}, 32'(out_valid[k]), 32'd1);
            chk({tag, ".hold_in_ready"}, 32'(in_ready[k]), 32'd0);
            check_out(k, {tag, ".hold"}, e_idx, e_mx, e_sc, e_mg);
        end
        in_valid[k]  = 1'b0;
        out_ready[k] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready[k] = 1'b0;
        chk({tag, ".valid_clr"}, 32'(out_valid[k]), 32'd0);
        chk({tag, ".ready_back"}, 32'(in_ready[k]), 32'd1);
        check_out(k, {tag, ".kept"}, e_idx, e_mx, e_sc, e_mg);
    endtask

    initial begin
        int s [10];
        logic [159:0] v;
        for (int k = 0; k < 3; k++) begin
            in_valid[k]  = 1'b0;
            in_data[k]   = '0;
            out_ready[k] = 1'b0;
        end
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            chk("rst.valid", 32'(out_valid[k]), 32'd0);
            chk("rst.in_ready", 32'(in_ready[k]), 32'd1);
            check_out(k, "rst", 4'd0, 16'd0, 16'd0, 16'd0);
        end

        s = '{3, 9, 1, 20, 7, 0, 5, 2, 8, 4};
        run(0, pack(s), 0, "uniq_l1");
        run(1, pack(s), 0, "uniq_l4");
        s = '{-5, -2, -9, -2, -8, -6, -3, -4, -10, -7};
        run(0, pack(s), 0, "neg_tie");
        run(1, pack(s), 0, "neg_tie_l4");
        s = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 'hFFFF};
        run(2, pack(s), 0, "unsigned");
        run(0, pack(s), 0, "ffff_signed");
        for (int i = 0; i < 10; i++) s[i] = int'($urandom_range(0, 1000));
        s[9] = 2000;
        run(1, pack(s), 0, "pad_l4");
        s = '{3, 9, 1, 20, 7, 0, 5, 2, 8, 4};
        run(0, pack(s), 5, "backpr");
        run(1, pack(s), 5, "backpr_l4");

        // Abandon a scan with reset, then confirm a fresh vector is processed cleanly.
        @(negedge clk);
        in_valid[0] = 1'b1;
        in_data[0]  = pack(s);
        @(posedge clk);
        @(negedge clk);
        in_valid[0] = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        in_valid[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("midrst.valid", 32'(out_valid[0]), 32'd0);
        check_out(0, "midrst", 4'd0, 16'd0, 16'd0, 16'd0);
        @(posedge clk);
        @(negedge clk);
        in_valid[0] = 1'b0;
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("midrst.in_ready", 32'(in_ready[0]), 32'd1);
        chk("midrst.no_out", 32'(out_valid[0]), 32'd0);
        s = '{-5, -2, -9, -2, -8, -6, -3, -4, -10, -7};
        run(0, pack(s), 0, "after_rst");

        for (int r = 0; r < 30; r++) begin
            for (int i = 0; i < 10; i++) begin
                if (r % 2 == 0) v[i*16 +: 16] = 16'($urandom_range(0, 3)) << 14;
                else            v[i*16 +: 16] = 16'($urandom);
            end
            run(r % 3, v, (r % 5 == 0) ? 2 : 0, "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
